// File: rtl/p2s_4bit_tx.sv
// Framed parallel-to-serial transmitter: a FIFO of WIDTH-bit words drained one frame every
// WIDTH clocks, LSB first. Idle frames fill the gaps so the downstream frame counter stays aligned.
module p2s_4bit_tx #(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             SOUT,
    output logic             FS,
    output logic             BUSY,
    output logic             UNDERRUN
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(WIDTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [BW-1:0]    r_bcnt;
    logic [WIDTH-1:0] r_shreg;
    logic             r_sout, r_fs, r_busy, r_underrun;

    logic             w_load, w_empty, w_push, w_pop;
    logic [WIDTH-1:0] w_word;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Ready comes from the registered count only; no path from DIN_VALID.
    assign w_empty   = (r_count == '0);
    assign w_load    = (r_bcnt == BIT_LAST);
    assign DIN_READY = !CLR && (r_count < CNT_FULL);
    assign w_push    = DIN_VALID && DIN_READY;
    assign w_pop     = w_load && !w_empty;
    assign w_word    = w_empty ? IDLE_WORD : r_mem[r_rd_ptr];

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= DIN;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Counter resets to the last bit so the first edge after release is a load edge.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_bcnt     <= BIT_LAST;
            r_shreg    <= '0;
            r_sout     <= 1'b0;
            r_fs       <= 1'b0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_bcnt <= w_load ? '0 : r_bcnt + 1'b1;
            if (w_load) begin
                r_sout     <= w_word[0];
                r_shreg    <= w_word >> 1;
                r_fs       <= 1'b1;
                r_busy     <= !w_empty;
                r_underrun <= w_empty && r_busy;
            end else begin
                r_sout     <= r_shreg[0];
                r_shreg    <= r_shreg >> 1;
                r_fs       <= 1'b0;
                r_underrun <= 1'b0;
            end
        end
    end

    assign SOUT     = r_sout;
    assign FS       = r_fs;
    assign BUSY     = r_busy;
    assign UNDERRUN = r_underrun;
endmodule

// File: tb/tb_p2s_4bit_tx.sv
// Randomized scoreboard bench for p2s_4bit_tx: a queue-based frame model predicts every frame,
// a monitor reassembles frames from SOUT/FS and compares them in order.
module tb_p2s_4bit_tx;
    localparam int         WIDTH = 4;
    localparam int         DEPTH = 2;
    localparam logic [3:0] IDLE  = 4'b0000;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic [3:0] DIN = '0;
    logic       DIN_VALID = 1'b0;
    logic       DIN_READY, SOUT, FS, BUSY, UNDERRUN;

    p2s_4bit_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDLE_WORD(IDLE)) dut (
        .CLK(CLK), .CLR(CLR), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
        .SOUT(SOUT), .FS(FS), .BUSY(BUSY), .UNDERRUN(UNDERRUN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] word;
        logic       busy;
        logic       und;
    } frame_t;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO as a queue, frame boundaries from an edge count since release.
    logic [3:0] mq[$];
    frame_t     exq[$];
    int         n = 0;
    bit         mbusy = 0;
    bit         acc_last = 0;

    always @(posedge CLK) begin
        if (!CLR) begin
            int s;
            s = mq.size();
            acc_last = 0;
            n++;
            if ((n - 1) % WIDTH == 0) begin
                frame_t f;
                if (s > 0) begin
                    f.word = mq.pop_front();
                    f.busy = 1'b1;
                end else begin
                    f.word = IDLE;
                    f.busy = 1'b0;
                end
                f.und = (s == 0) && mbusy;
                mbusy = f.busy;
                exq.push_back(f);
            end
            if (DIN_VALID && s < DEPTH) begin
                mq.push_back(DIN);
                acc_last = 1;
            end
        end
    end

    // Monitor: reassemble each frame starting at FS and score it against the model.
    logic [3:0] cap;
    int         idx = -1;
    bit         cbusy, cund, ferr;

    always @(negedge CLK) begin
        if (!CLR) begin
            chk("din_ready", DIN_READY, mq.size() < DEPTH);
            chk("fs", FS, n > 0 && (n - 1) % WIDTH == 0);
            if (FS) begin
                idx = 0;
                cbusy = BUSY;
                cund = UNDERRUN;
                ferr = 0;
            end
            if (idx >= 0) begin
                cap[idx] = SOUT;
                if (idx > 0 && (BUSY !== cbusy || UNDERRUN !== 1'b0)) ferr = 1;
                idx++;
                if (idx == WIDTH) begin
                    if (exq.size() == 0) chk("frame_expected", 0, 1);
                    else begin
                        frame_t f;
                        f = exq.pop_front();
                        chk("frame_word", cap, f.word);
                        chk("frame_busy", {ferr, cbusy}, {1'b0, f.busy});
                        chk("frame_underrun", cund, f.und);
                    end
                    idx = -1;
                end
            end
        end
    end

    task automatic send(input logic [3:0] w);
        int t = 0;
        DIN = w;
        DIN_VALID = 1'b1;
        do begin
            @(negedge CLK);
            t++;
        end while (!acc_last && t < 100);
        if (!acc_last) chk("accept_timeout", 0, 1);
        DIN_VALID = 1'b0;
    endtask

    task automatic idle(input int k);
        DIN_VALID = 1'b0;
        repeat (k) @(negedge CLK);
    endtask

    task automatic reset_outputs_chk(input string tag);
        chk({tag, "_sout"}, SOUT, 0);
        chk({tag, "_fs"}, FS, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_underrun"}, UNDERRUN, 0);
        chk({tag, "_ready"}, DIN_READY, 0);
    endtask

    initial begin
        int t;
        #3 reset_outputs_chk("por");
        @(negedge CLK);
        #2 CLR = 1'b0;
        @(negedge CLK);

        // Idle framing, then a single word followed by an underrun.
        idle(8);
        send(4'b1011);
        idle(12);

        // Back-to-back stream; FIFO fills and frames run contiguous.
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        idle(20);

        // Word held against a full FIFO until a pop frees a slot.
        send(4'hA); send(4'h5); send(4'hC);
        idle(20);

        // Push on a load edge with an empty FIFO: idle frame comes first.
        t = 0;
        while (!(mq.size() == 0 && n % WIDTH == 0) && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk("align_load_edge", n % WIDTH, 0);
        send(4'hF);
        idle(12);

        repeat (60) begin
            send(4'($urandom));
            idle($urandom_range(0, 6));
        end

        // Reset mid data frame with a word still queued.
        send(4'h9); send(4'h6);
        t = 0;
        while (!(mbusy && (n - 1) % WIDTH == 1) && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk("reach_mid_frame", mbusy, 1);
        #1 CLR = 1'b1;
        #1 reset_outputs_chk("mid_reset");
        mq.delete();
        exq.delete();
        n = 0;
        mbusy = 0;
        idx = -1;
        repeat (2) @(negedge CLK);
        #2 CLR = 1'b0;
        @(negedge CLK);
        idle(12);

        repeat (15) begin
            send(4'($urandom));
            idle($urandom_range(0, 3));
        end
        idle(24);
        chk("drain_frames", exq.size() <= 1, 1);
        chk("drain_fifo", mq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
